// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state encodings,
// default widths and the baud constants used alongside the transmitter.
package uart_tx_sched_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned BAUD_RATE = 9600;
  localparam int unsigned BAUD_DIV  = CLK_HZ / BAUD_RATE;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIFO_RD   = 3'd1,
    ST_FIFO_CAP  = 3'd2,
    ST_MSG_ACK   = 3'd3,
    ST_START     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of the FIFO, message, transmitter and status signals around the
// scheduler; master is the scheduler's view, slave the surrounding logic.
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              msg_valid;
  logic [DATA_W-1:0] msg_data;
  logic              msg_ready;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic              busy;
  logic              grant_src;
  logic              err_timeout;
  logic [15:0]       frame_cnt;

  modport master (
    input  fifo_empty, fifo_dout, msg_valid, msg_data, tx_done,
    output fifo_rd_en, msg_ready, tx_start, tx_data, busy, grant_src,
           err_timeout, frame_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, msg_valid, msg_data, tx_done,
    input  fifo_rd_en, msg_ready, tx_start, tx_data, busy, grant_src,
           err_timeout, frame_cnt
  );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-requester round-robin arbiter: a lone request wins outright, a tie
// goes to the requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a FIFO and a direct message port:
// fetch a byte, pulse tx_start, wait for tx_done (with watchdog), then gap.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEF,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 32'd2000000,
  parameter int          CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] tx_data_r;
  logic              grant_src_r;
  logic              err_r;
  logic [15:0]       frame_cnt_r;
  logic              done_hit;
  logic              to_hit;

  assign req      = {bus.msg_valid, ~bus.fifo_empty};
  assign done_hit = (state == ST_WAIT_DONE) && bus.tx_done;
  assign to_hit   = (state == ST_WAIT_DONE) && !bus.tx_done && (cnt == TO_LAST);

  rr_arb2 u_arb (
    .req   (req),
    .last  (grant_src_r),
    .grant (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt[0])      state_nxt = ST_FIFO_RD;
        else if (gnt[1]) state_nxt = ST_MSG_ACK;
      end
      ST_FIFO_RD:  state_nxt = ST_FIFO_CAP;
      ST_FIFO_CAP: state_nxt = ST_START;
      ST_MSG_ACK:  state_nxt = bus.msg_valid ? ST_START : ST_IDLE;
      ST_START:    state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_hit || to_hit) state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control: shared counter, grant history, sticky error, frame count.
  // The counter is zeroed on every exit from WAIT_DONE so GAP starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      grant_src_r <= 1'b1;
      err_r       <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) grant_src_r <= gnt[1];
        end
        ST_START: cnt <= '0;
        ST_WAIT_DONE: begin
          if (done_hit) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            cnt         <= '0;
          end else if (to_hit) begin
            err_r <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP:  cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Data capture: held from START through the end of WAIT_DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_r <= '0;
    end else if (state == ST_FIFO_CAP) begin
      tx_data_r <= bus.fifo_dout;
    end else if ((state == ST_MSG_ACK) && bus.msg_valid) begin
      tx_data_r <= bus.msg_data;
    end
  end

  assign bus.fifo_rd_en  = (state == ST_FIFO_RD);
  assign bus.msg_ready   = (state == ST_MSG_ACK) && bus.msg_valid;
  assign bus.tx_start    = (state == ST_START);
  assign bus.tx_data     = tx_data_r;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.grant_src   = grant_src_r;
  assign bus.err_timeout = err_r;
  assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural FIFO and message source.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] exp_data[4];
  logic       exp_src[4];
  bit         found;

  uart_tx_sched_if #(.DATA_W(8)) bif ();

  uart_tx_sched #(
    .DATA_W     (8),
    .GAP_CYCLES (16),
    .TIMEOUT    (100),
    .CNT_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock; serves the FIFO read and message handshakes seen in the
  // cycle just ending, then leaves inputs stable for the new cycle.
  task automatic tick();
    logic rd;
    logic rdy;
    rd  = bif.fifo_rd_en;
    rdy = bif.msg_ready;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) bif.fifo_dout = fq.pop_front();
    bif.fifo_empty = (fq.size() == 0);
    if (rdy) begin
      if (mq.size() > 0) bif.msg_data = mq.pop_front();
      else               bif.msg_valid = 1'b0;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (bif.tx_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic finish_frame();
    tick();
    bif.tx_done = 1'b1;
    tick();
    bif.tx_done = 1'b0;
    repeat (15) tick();
  endtask

  initial begin
    bif.fifo_empty = 1'b1;
    bif.fifo_dout  = 8'h00;
    bif.msg_valid  = 1'b0;
    bif.msg_data   = 8'h00;
    bif.tx_done    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_busy",      bif.busy, 0);
    chk("rst_grant_src", bif.grant_src, 1);
    chk("rst_err",       bif.err_timeout, 0);
    chk("rst_frame_cnt", bif.frame_cnt, 0);
    chk("rst_tx_data",   bif.tx_data, 0);
    chk("rst_strobes",   {bif.fifo_rd_en, bif.msg_ready, bif.tx_start}, 0);

    // FIFO path latency, byte 0xA5
    fq.push_back(8'hA5);
    bif.fifo_empty = 1'b0;
    tick();
    chk("fifo_rd_en_k1", bif.fifo_rd_en, 1);
    chk("fifo_grant_src", bif.grant_src, 0);
    chk("fifo_start_k1", bif.tx_start, 0);
    tick();
    chk("fifo_rd_en_k2", bif.fifo_rd_en, 0);
    chk("fifo_start_k2", bif.tx_start, 0);
    tick();
    chk("fifo_start_k3", bif.tx_start, 1);
    chk("fifo_tx_data",  bif.tx_data, 8'hA5);
    tick();
    chk("fifo_start_k4", bif.tx_start, 0);
    chk("fifo_busy_wait", bif.busy, 1);
    bif.tx_done = 1'b1;
    tick();
    bif.tx_done = 1'b0;
    chk("fifo_frame_cnt", bif.frame_cnt, 1);
    repeat (15) tick();
    chk("gap_busy_last", bif.busy, 1);
    tick();
    chk("gap_busy_idle", bif.busy, 0);

    // Message path latency, byte 0x3C
    bif.msg_valid = 1'b1;
    bif.msg_data  = 8'h3C;
    tick();
    chk("msg_ready_k1", bif.msg_ready, 1);
    chk("msg_grant_src", bif.grant_src, 1);
    chk("msg_start_k1", bif.tx_start, 0);
    tick();
    chk("msg_ready_k2", bif.msg_ready, 0);
    chk("msg_start_k2", bif.tx_start, 1);
    chk("msg_tx_data",  bif.tx_data, 8'h3C);
    finish_frame();
    tick();
    chk("msg_frame_cnt", bif.frame_cnt, 2);
    chk("msg_idle", bif.busy, 0);

    // Both sources pending: round robin alternation
    exp_data = '{8'h11, 8'h55, 8'h22, 8'h66};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    bif.fifo_empty = 1'b0;
    bif.msg_data   = 8'h55;
    bif.msg_valid  = 1'b1;
    mq.push_back(8'h66);
    for (int f = 0; f < 4; f++) begin
      wait_start(found);
      chk($sformatf("rr_start_%0d", f), found, 1);
      chk($sformatf("rr_data_%0d", f), bif.tx_data, exp_data[f]);
      chk($sformatf("rr_src_%0d", f), bif.grant_src, exp_src[f]);
      finish_frame();
    end
    tick();
    chk("rr_frame_cnt", bif.frame_cnt, 6);
    chk("rr_msg_drained", bif.msg_valid, 0);

    // Watchdog: tx_done never returned
    fq.push_back(8'h77);
    bif.fifo_empty = 1'b0;
    wait_start(found);
    chk("to_start", found, 1);
    repeat (100) tick();
    chk("to_err_before", bif.err_timeout, 0);
    tick();
    chk("to_err_set", bif.err_timeout, 1);
    chk("to_busy_gap", bif.busy, 1);
    chk("to_frame_cnt", bif.frame_cnt, 6);
    repeat (16) tick();
    chk("to_idle", bif.busy, 0);

    bif.msg_data  = 8'h9A;
    bif.msg_valid = 1'b1;
    wait_start(found);
    chk("after_to_start", found, 1);
    chk("after_to_data", bif.tx_data, 8'h9A);
    finish_frame();
    tick();
    chk("after_to_frame_cnt", bif.frame_cnt, 7);
    chk("after_to_err_sticky", bif.err_timeout, 1);

    // msg_valid withdrawn during MSG_ACK
    bif.msg_data  = 8'hEE;
    bif.msg_valid = 1'b1;
    tick();
    chk("drop_in_ack", bif.busy, 1);
    bif.msg_valid = 1'b0;
    #1;
    chk("drop_ready", bif.msg_ready, 0);
    tick();
    chk("drop_start", bif.tx_start, 0);
    chk("drop_idle", bif.busy, 0);
    tick();
    chk("drop_start2", bif.tx_start, 0);
    chk("drop_tx_data", bif.tx_data, 8'h9A);

    // Stray tx_done in IDLE
    bif.tx_done = 1'b1;
    tick();
    bif.tx_done = 1'b0;
    tick();
    chk("stray_frame_cnt", bif.frame_cnt, 7);
    chk("stray_idle", bif.busy, 0);

    // Reset in the middle of WAIT_DONE
    fq.push_back(8'h42);
    bif.fifo_empty = 1'b0;
    wait_start(found);
    chk("rst_mid_start", found, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", bif.busy, 0);
    chk("rst_mid_start_out", bif.tx_start, 0);
    chk("rst_mid_grant_src", bif.grant_src, 1);
    chk("rst_mid_err", bif.err_timeout, 0);
    chk("rst_mid_frame_cnt", bif.frame_cnt, 0);
    chk("rst_mid_tx_data", bif.tx_data, 0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
